// File: rtl/jx2_add48_arbiter.sv
// Round-robin arbiter in front of one shared 48-bit carry-select adder (S1 operands, S2 sum).
// Optional macro JX2_ADD48_SXTUPPER_EN sign-extends the 48-bit sum into valc[63:48].
module jx2_add48_arbiter #(
  parameter int NREQ = 3,
  parameter int IDW  = 2,
  parameter int TAGW = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_vala,
  input  logic [64*NREQ-1:0]   req_valb,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [63:0]          rsp_valc
);

  // Handshake: a beat moves on a port when valid & ready are both high at the rising edge;
  // req_ready is derived from req_valid, never the other way round.

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  nextPtr;
  logic [IDW-1:0]  cand;
  logic            candFound;
  logic [IDW:0]    searchIdx;
  logic            s1V;
  logic [47:0]     s1A;
  logic [47:0]     s1B;
  logic [TAGW-1:0] s1Tag;
  logic [IDW-1:0]  s1Id;
  logic            s1Adv;
  logic            s2Adv;
  logic            xfer;
  logic [47:0]     selA;
  logic [47:0]     selB;
  logic [TAGW-1:0] selTag;
  logic [16:0]     seg0;
  logic [16:0]     seg1c0;
  logic [16:0]     seg1c1;
  logic [16:0]     seg1;
  logic [15:0]     seg2c0;
  logic [15:0]     seg2c1;
  logic [15:0]     seg2;
  logic [47:0]     sum48;
  logic [15:0]     upper;

  assign s2Adv = !rsp_valid || rsp_ready;
  assign s1Adv = !s1V || s2Adv;

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    cand      = '0;
    candFound = 1'b0;
    searchIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      searchIdx = {1'b0, ptr} + (IDW+1)'(k);
      if (searchIdx >= (IDW+1)'(NREQ))
        searchIdx = searchIdx - (IDW+1)'(NREQ);
      if (!candFound && req_valid[searchIdx[IDW-1:0]]) begin
        candFound = 1'b1;
        cand      = searchIdx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && candFound && s1Adv)
      req_ready[cand] = 1'b1;
  end

  assign xfer    = reset && candFound && s1Adv;
  assign nextPtr = (cand == IDW'(NREQ-1)) ? '0 : cand + IDW'(1);

  always_comb begin
    selA   = req_vala[int'(cand)*64 +: 48];
    selB   = req_valb[int'(cand)*64 +: 48];
    selTag = req_tag[int'(cand)*TAGW +: TAGW];
  end

  // Carry-select: upper segments precompute both carry-in cases, low carries pick one.
  always_comb begin
    seg0   = {1'b0, s1A[15:0]} + {1'b0, s1B[15:0]};
    seg1c0 = {1'b0, s1A[31:16]} + {1'b0, s1B[31:16]};
    seg1c1 = seg1c0 + 17'd1;
    seg1   = seg0[16] ? seg1c1 : seg1c0;
    seg2c0 = s1A[47:32] + s1B[47:32];
    seg2c1 = seg2c0 + 16'd1;
    seg2   = seg1[16] ? seg2c1 : seg2c0;
    sum48  = {seg2, seg1[15:0], seg0[15:0]};
  end

`ifdef JX2_ADD48_SXTUPPER_EN
  assign upper = {16{sum48[47]}};
`else
  assign upper = 16'h0000;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      s1V       <= 1'b0;
      s1A       <= '0;
      s1B       <= '0;
      s1Tag     <= '0;
      s1Id      <= '0;
      rsp_valid <= 1'b0;
      rsp_valc  <= '0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
    end else begin
      if (xfer) begin
        ptr   <= nextPtr;
        s1V   <= 1'b1;
        s1A   <= selA;
        s1B   <= selB;
        s1Tag <= selTag;
        s1Id  <= cand;
      end else if (s1Adv) begin
        s1V <= 1'b0;
      end
      // S2 refill and drain may coincide; the outgoing beat is consumed at this same edge.
      if (s1V && s2Adv) begin
        rsp_valid <= 1'b1;
        rsp_valc  <= {upper, sum48};
        rsp_id    <= s1Id;
        rsp_tag   <= s1Tag;
      end else if (s2Adv) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jx2_add48_arbiter.sv
// Directed bench for jx2_add48_arbiter: reset, arithmetic corners, fairness and backpressure.
module tb_jx2_add48_arbiter;
  localparam int NREQ = 3;
  localparam int IDW  = 2;
  localparam int TAGW = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_vala;
  logic [64*NREQ-1:0]   req_valb;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [63:0]          rsp_valc;

  int checks = 0;
  int passes = 0;

  logic [63:0]     exp_q[$];
  logic [TAGW-1:0] tag_q[$];

  jx2_add48_arbiter #(.NREQ(NREQ), .IDW(IDW), .TAGW(TAGW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vala(req_vala), .req_valb(req_valb), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_valc(rsp_valc)
  );

  always #5 clock = ~clock;

  task automatic drive_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [TAGW-1:0] t);
    req_vala[64*i +: 64]    = a;
    req_valb[64*i +: 64]    = b;
    req_tag[TAGW*i +: TAGW] = t;
    req_valid[i]            = 1'b1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = '1;
    repeat (2) @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); else passes++;
    checks++; if (rsp_valc !== 64'h0) $display("FAIL reset_rsp_valc got=%h want=0", rsp_valc); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); else passes++;
    checks++; if (rsp_tag !== 4'd0) $display("FAIL reset_rsp_tag got=%0d want=0", rsp_tag); else passes++;
    checks++; if (req_ready !== 3'b000) $display("FAIL reset_req_ready got=%b want=000", req_ready); else passes++;
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL reset_ptr0 got=%b want=001", req_ready); else passes++;
    clear_reqs();
  endtask

  task automatic test_single();
    @(negedge clock);
    rsp_ready = 1'b1;
    drive_req(1, 64'h0000_0000_0000_FFFF, 64'h1, 4'd5);
    #1;
    checks++; if (req_ready !== 3'b010) $display("FAIL single_grant got=%b want=010", req_ready); else passes++;
    @(negedge clock);
    clear_reqs();
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%0b want=0", rsp_valid); else passes++;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid got=%0b want=1", rsp_valid); else passes++;
    checks++; if (rsp_valc !== 64'h0000_0000_0001_0000) $display("FAIL single_valc got=%h want=10000", rsp_valc); else passes++;
    checks++; if (rsp_id !== 2'd1) $display("FAIL single_id got=%0d want=1", rsp_id); else passes++;
    checks++; if (rsp_tag !== 4'd5) $display("FAIL single_tag got=%0d want=5", rsp_tag); else passes++;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_sx;
`ifdef JX2_ADD48_SXTUPPER_EN
    exp_sx = 64'hFFFF_8000_0000_0000;
`else
    exp_sx = 64'h0000_8000_0000_0000;
`endif
    @(negedge clock);
    drive_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'hA);
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL wrap_grant_wrapped got=%b want=001", req_ready); else passes++;
    @(negedge clock);
    clear_reqs();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_valc !== 64'h0) $display("FAIL wrap_allones got=%h v=%0b want=0", rsp_valc, rsp_valid); else passes++;
    checks++; if (rsp_tag !== 4'hA || rsp_id !== 2'd0) $display("FAIL wrap_allones_idtag got=%0d/%h want=0/a", rsp_id, rsp_tag); else passes++;
    drive_req(0, 64'h0000_7FFF_FFFF_FFFF, 64'h1, 4'h3);
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL wrap_grant2 got=%b want=001", req_ready); else passes++;
    @(negedge clock);
    clear_reqs();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_valc !== exp_sx) $display("FAIL wrap_bit47 got=%h want=%h", rsp_valc, exp_sx); else passes++;
  endtask

  task automatic test_upper_ignored();
    @(negedge clock);
    drive_req(2, 64'hABCD_0000_0000_0002, 64'h1234_0000_0000_0003, 4'h7);
    #1;
    checks++; if (req_ready !== 3'b100) $display("FAIL upper_grant got=%b want=100", req_ready); else passes++;
    @(negedge clock);
    clear_reqs();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_valc !== 64'h5) $display("FAIL upper_valc got=%h want=5", rsp_valc); else passes++;
    checks++; if (rsp_id !== 2'd2 || rsp_tag !== 4'h7) $display("FAIL upper_idtag got=%0d/%h want=2/7", rsp_id, rsp_tag); else passes++;
  endtask

  task automatic test_reset_midflight();
    @(negedge clock);
    rsp_ready = 1'b0;
    drive_req(0, 64'h100, 64'h23, 4'd1);
    @(negedge clock);
    clear_reqs();
    drive_req(1, 64'h200, 64'h45, 4'd2);
    #1;
    checks++; if (req_ready !== 3'b010) $display("FAIL mid_grant1 got=%b want=010", req_ready); else passes++;
    @(negedge clock);
    clear_reqs();
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_valc !== 64'h123) $display("FAIL mid_s2_full got=%h v=%0b want=123", rsp_valc, rsp_valid); else passes++;
    #1 reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_async_clear got=%0b want=0", rsp_valid); else passes++;
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 3'b000) $display("FAIL mid_ready_in_reset got=%b want=000", req_ready); else passes++;
    @(negedge clock);
    reset = 1'b1;
    clear_reqs();
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_stale_rsp cyc=%0d got=%0b want=0", c, rsp_valid); else passes++;
    end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 3'b001) $display("FAIL mid_ptr0 got=%b want=001", req_ready); else passes++;
    clear_reqs();
  endtask

  task automatic test_fairness();
    int          eid;
    logic [63:0] esum;
    @(negedge clock);
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 0)
        for (int i = 0; i < NREQ; i++)
          drive_req(i, 64'(i+1) << 20, 64'(3*i+1), 4'(i+8));
      if (k == 6) clear_reqs();
      #1;
      if (k < 6) begin
        checks++;
        if (req_ready !== 3'(1 << (k % 3))) $display("FAIL fair_grant k=%0d got=%b want=%b", k, req_ready, 3'(1 << (k % 3)));
        else passes++;
      end
      if (k >= 2 && k < 8) begin
        eid  = (k - 2) % 3;
        esum = (64'(eid+1) << 20) + 64'(3*eid+1);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(eid) || rsp_valc !== esum || rsp_tag !== 4'(eid+8))
          $display("FAIL fair_rsp k=%0d got v=%0b id=%0d valc=%h want id=%0d valc=%h", k, rsp_valid, rsp_id, rsp_valc, eid, esum);
        else passes++;
      end
      if (k == 8) begin
        checks++; if (rsp_valid !== 1'b0) $display("FAIL fair_idle got=%0b want=0", rsp_valid); else passes++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    int              n = 0;
    int              got = 0;
    logic [63:0]     held_valc;
    logic [TAGW-1:0] held_tag;
    @(negedge clock);
    for (int c = 0; c < 24; c++) begin
      rsp_ready = !(c >= 3 && c <= 6);
      if (c < 14) drive_req(0, (64'(n) << 16) | 64'hFFFF, 64'h1, 4'(n));
      else clear_reqs();
      #1;
      if (!rsp_ready) begin
        checks++; if (req_ready !== 3'b000) $display("FAIL bp_ready_drop c=%0d got=%b want=000", c, req_ready); else passes++;
        if (c == 3) begin
          checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_stall_valid got=%0b want=1", rsp_valid); else passes++;
          held_valc = rsp_valc;
          held_tag  = rsp_tag;
        end else begin
          checks++;
          if (rsp_valid !== 1'b1 || rsp_valc !== held_valc || rsp_tag !== held_tag)
            $display("FAIL bp_hold c=%0d got=%h/%h want=%h/%h", c, rsp_valc, rsp_tag, held_valc, held_tag);
          else passes++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra_rsp got=%h want=none", rsp_valc);
        else if (rsp_valc !== exp_q[0] || rsp_tag !== tag_q[0] || rsp_id !== 2'd0)
          $display("FAIL bp_order got=%h/%h want=%h/%h", rsp_valc, rsp_tag, exp_q[0], tag_q[0]);
        else passes++;
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        got++;
      end
      if (req_valid[0] && req_ready[0]) begin
        exp_q.push_back(64'(n+1) << 16);
        tag_q.push_back(4'(n));
        n++;
      end
      @(negedge clock);
    end
    checks++; if (exp_q.size() != 0) $display("FAIL bp_lost got=%0d pending want=0", exp_q.size()); else passes++;
    checks++; if (got != n || n < 8) $display("FAIL bp_count got=%0d rsp want=%0d accepted (>=8)", got, n); else passes++;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_vala  = '0;
    req_valb  = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_upper_ignored();
    test_reset_midflight();
    test_fairness();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
